// File: rtl/sudoku_pkg.sv
// Shared widths, FSM state encoding and a saturating-increment helper
// for the Sudoku auto player.
package sudoku_pkg;

    localparam int unsigned CELL_W = 4;
    localparam int unsigned VAL_W  = 2;
    localparam int unsigned MOVE_W = CELL_W + VAL_W;
    localparam int unsigned NUM_W  = 5;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StWaitRdy  = 3'd1,
        StSetup    = 3'd2,
        StEnter    = 3'd3,
        StWaitResp = 3'd4,
        StWaitWin  = 3'd5,
        StDone     = 3'd6
    } state_e;

    function automatic logic [NUM_W-1:0] sat_inc(input logic [NUM_W-1:0] v);
        return (&v) ? v : v + NUM_W'(1);
    endfunction

endpackage

// File: rtl/sudoku_move_buf.sv
// Move list storage: one synchronous write port, asynchronous read by move index.
// Contents are deliberately not reset so a loaded script survives a restart.
module sudoku_move_buf
    import sudoku_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [MOVE_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [MOVE_W-1:0] rd_data
);

    logic [MOVE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sudoku_auto_player.sv
// Scripted Sudoku player: replays the buffered move list through the game's
// choose/value/enter interface, following its ready/accept/try-again/won replies.
module sudoku_auto_player
    import sudoku_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned TIMEOUT   = 15,
    parameter int unsigned MAX_RETRY = 2
) (
    input  logic              in_clka,
    input  logic              in_restart_n,
    input  logic              in_start,
    input  logic              in_wr_en,
    input  logic [3:0]        in_wr_addr,
    input  logic [CELL_W-1:0] in_wr_cell,
    input  logic [VAL_W-1:0]  in_wr_value,
    input  logic [NUM_W-1:0]  in_num_moves,
    input  logic              in_register_inp_flag,
    input  logic              in_dp_check,
    input  logic              in_try_again_flag,
    input  logic              in_won,
    output logic              out_enter,
    output logic [CELL_W-1:0] out_reg_choose,
    output logic [VAL_W-1:0]  out_value_inp,
    output logic              out_busy,
    output logic              out_done,
    output logic              out_win,
    output logic              out_timeout,
    output logic [NUM_W-1:0]  out_reject_cnt,
    output logic [NUM_W-1:0]  out_move_idx,
    output logic [2:0]        out_state
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
    localparam int unsigned RTY_W = $clog2(MAX_RETRY + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(MAX_RETRY - 1);

    state_e            state_q, state_d;
    logic [NUM_W-1:0]  num_q, num_d, idx_q, idx_d, reject_q, reject_d;
    logic [RTY_W-1:0]  retry_q, retry_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              done_q, done_d, win_q, win_d, timeout_q, timeout_d;
    logic [CELL_W-1:0] choose_q, choose_d;
    logic [VAL_W-1:0]  value_q, value_d;
    logic [MOVE_W-1:0] rd_move;
    logic [NUM_W-1:0]  num_clamped;
    logic              busy, buf_we, advance;

    assign busy        = (state_q != StIdle) && (state_q != StDone);
    assign buf_we      = in_wr_en && !busy;
    assign num_clamped = (in_num_moves > NUM_W'(DEPTH)) ? NUM_W'(DEPTH) : in_num_moves;

    sudoku_move_buf #(
        .DEPTH  (DEPTH),
        .ADDR_W (AW)
    ) u_move_buf (
        .clk     (in_clka),
        .wr_en   (buf_we),
        .wr_addr (in_wr_addr[AW-1:0]),
        .wr_data ({in_wr_cell, in_wr_value}),
        .rd_addr (idx_q[AW-1:0]),
        .rd_data (rd_move)
    );

    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        idx_d     = idx_q;
        retry_d   = retry_q;
        reject_d  = reject_q;
        timer_d   = timer_q;
        done_d    = done_q;
        win_d     = win_q;
        timeout_d = timeout_q;
        choose_d  = choose_q;
        value_d   = value_q;
        advance   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_start) begin
                    num_d     = num_clamped;
                    idx_d     = '0;
                    retry_d   = '0;
                    reject_d  = '0;
                    timer_d   = '0;
                    done_d    = 1'b0;
                    win_d     = 1'b0;
                    timeout_d = 1'b0;
                    state_d   = (num_clamped == '0) ? StWaitWin : StWaitRdy;
                end
            end
            StWaitRdy: begin
                if (in_won) begin
                    win_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = StDone;
                end else if (in_register_inp_flag) begin
                    // Load the move here so it is stable for the whole setup cycle.
                    choose_d = rd_move[MOVE_W-1:VAL_W];
                    value_d  = rd_move[VAL_W-1:0];
                    state_d  = StSetup;
                end
            end
            StSetup: state_d = StEnter;
            StEnter: begin
                timer_d = '0;
                state_d = StWaitResp;
            end
            StWaitResp: begin
                if (in_won) begin
                    win_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = StDone;
                end else if (in_try_again_flag) begin
                    if (retry_q == RTY_LAST) begin
                        reject_d = sat_inc(reject_q);
                        retry_d  = '0;
                        advance  = 1'b1;
                    end else begin
                        retry_d = retry_q + RTY_W'(1);
                        state_d = StWaitRdy;
                    end
                end else if (in_dp_check) begin
                    retry_d = '0;
                    advance = 1'b1;
                end else if (timer_q == TMR_LAST) begin
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = StDone;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            StWaitWin: begin
                if (in_won) begin
                    win_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = StDone;
                end else if (timer_q == TMR_LAST) begin
                    done_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (advance) begin
            idx_d   = sat_inc(idx_q);
            timer_d = '0;
            state_d = (sat_inc(idx_q) == num_q) ? StWaitWin : StWaitRdy;
        end
    end

    always_ff @(posedge in_clka or negedge in_restart_n) begin
        if (!in_restart_n) begin
            state_q   <= StIdle;
            num_q     <= '0;
            idx_q     <= '0;
            retry_q   <= '0;
            reject_q  <= '0;
            timer_q   <= '0;
            done_q    <= 1'b0;
            win_q     <= 1'b0;
            timeout_q <= 1'b0;
            choose_q  <= '0;
            value_q   <= '0;
        end else begin
            state_q   <= state_d;
            num_q     <= num_d;
            idx_q     <= idx_d;
            retry_q   <= retry_d;
            reject_q  <= reject_d;
            timer_q   <= timer_d;
            done_q    <= done_d;
            win_q     <= win_d;
            timeout_q <= timeout_d;
            choose_q  <= choose_d;
            value_q   <= value_d;
        end
    end

    assign out_enter      = (state_q == StEnter);
    assign out_reg_choose = choose_q;
    assign out_value_inp  = value_q;
    assign out_busy       = busy;
    assign out_done       = done_q;
    assign out_win        = win_q;
    assign out_timeout    = timeout_q;
    assign out_reject_cnt = reject_q;
    assign out_move_idx   = idx_q;
    assign out_state      = state_q;

endmodule

// File: tb/tb_sudoku_auto_player.sv
// Bench for sudoku_auto_player: expected moves are queued when a replay is started
// and popped by a monitor on every enter strobe; each scenario task checks its own outcome.
module tb_sudoku_auto_player;

    localparam logic [2:0] S_IDLE = 3'd0, S_WRDY = 3'd1, S_SETUP = 3'd2, S_ENTER = 3'd3;
    localparam logic [2:0] S_WRESP = 3'd4, S_WWIN = 3'd5, S_DONE = 3'd6;

    logic       clk = 1'b0;
    logic       restart_n, start, wr_en, ready, dp, ta, won;
    logic [3:0] wr_addr, wr_cell;
    logic [1:0] wr_value;
    logic [4:0] num;
    logic       enter, busy, done, win, tmo;
    logic [3:0] choose;
    logic [1:0] value;
    logic [4:0] reject_cnt, move_idx;
    logic [2:0] state;

    int         check_cnt = 0;
    int         pass_cnt  = 0;
    int         enter_cnt = 0;
    int         base;
    logic [5:0] exp_q[$];
    logic [5:0] mon_e, prev_mv;
    logic       prev_enter;
    logic [2:0] prev_state;

    sudoku_auto_player dut (
        .in_clka              (clk),
        .in_restart_n         (restart_n),
        .in_start             (start),
        .in_wr_en             (wr_en),
        .in_wr_addr           (wr_addr),
        .in_wr_cell           (wr_cell),
        .in_wr_value          (wr_value),
        .in_num_moves         (num),
        .in_register_inp_flag (ready),
        .in_dp_check          (dp),
        .in_try_again_flag    (ta),
        .in_won               (won),
        .out_enter            (enter),
        .out_reg_choose       (choose),
        .out_value_inp        (value),
        .out_busy             (busy),
        .out_done             (done),
        .out_win              (win),
        .out_timeout          (tmo),
        .out_reject_cnt       (reject_cnt),
        .out_move_idx         (move_idx),
        .out_state            (state)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every enter must carry the next queued move after a setup cycle.
    initial begin
        prev_enter = 1'b0;
        prev_state = 3'd0;
        prev_mv    = 6'd0;
        forever begin
            @(negedge clk);
            if (restart_n !== 1'b1) begin
                prev_enter = 1'b0;
                prev_state = 3'd0;
            end else begin
                if (enter === 1'b1) begin
                    enter_cnt++;
                    check_cnt++;
                    if (prev_enter) $display("FAIL enter_width: enter high on two consecutive cycles");
                    else pass_cnt++;
                    check_cnt++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL unexpected_enter: got move %h, none queued", {choose, value});
                    end else begin
                        pass_cnt++;
                        mon_e = exp_q.pop_front();
                        check_cnt++;
                        if ({choose, value} !== mon_e)
                            $display("FAIL move: got %h want %h", {choose, value}, mon_e);
                        else pass_cnt++;
                        check_cnt++;
                        if (prev_state !== S_SETUP || prev_mv !== mon_e)
                            $display("FAIL setup: prev state %0d move %h want state 2 move %h",
                                     prev_state, prev_mv, mon_e);
                        else pass_cnt++;
                    end
                end
                prev_enter = enter;
                prev_state = state;
                prev_mv    = {choose, value};
            end
        end
    end

    task automatic load_move(input logic [3:0] a, input logic [3:0] c, input logic [1:0] v);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_cell = c; wr_value = v;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic start_replay(input logic [4:0] n);
        @(negedge clk);
        start = 1'b1; num = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_enter(input string tag);
        int n;
        n = 0;
        while (enter !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (enter !== 1'b1) begin
            check_cnt++;
            $display("FAIL %s_enter_wait: no enter within 40 cycles", tag);
        end
    endtask

    task automatic reply(input logic acc, input logic rej);
        @(negedge clk);
        dp = acc; ta = rej;
        @(negedge clk);
        dp = 1'b0; ta = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        check_cnt++;
        if ({enter, busy, done, win, tmo, reject_cnt, move_idx, state, choose, value} !== '0)
            $display("FAIL reset_outputs: got enter%b busy%b done%b win%b tmo%b rej%0d idx%0d st%0d want all 0",
                     enter, busy, done, win, tmo, reject_cnt, move_idx, state);
        else pass_cnt++;
        restart_n = 1'b1;
    endtask

    task automatic test_basic;
        load_move(4'd0, 4'd3, 2'd1);
        load_move(4'd1, 4'd4, 2'd2);
        load_move(4'd2, 4'd9, 2'd0);
        exp_q.push_back({4'd3, 2'd1});
        exp_q.push_back({4'd4, 2'd2});
        exp_q.push_back({4'd9, 2'd0});
        ready = 1'b1;
        base  = enter_cnt;
        start_replay(5'd3);
        repeat (3) begin
            wait_enter("basic");
            reply(1'b1, 1'b0);
        end
        check_cnt++;
        if (state !== S_WWIN || move_idx !== 5'd3 || busy !== 1'b1)
            $display("FAIL basic_wait_win: got st%0d idx%0d busy%b want st5 idx3 busy1", state, move_idx, busy);
        else pass_cnt++;
        won = 1'b1;
        @(negedge clk);
        check_cnt++;
        if (state !== S_DONE || done !== 1'b1 || win !== 1'b1 || busy !== 1'b0 || tmo !== 1'b0)
            $display("FAIL basic_done: got st%0d done%b win%b busy%b tmo%b want st6 done1 win1 busy0 tmo0",
                     state, done, win, busy, tmo);
        else pass_cnt++;
        won = 1'b0;
        @(negedge clk);
        check_cnt++;
        if (state !== S_IDLE || done !== 1'b1 || win !== 1'b1 || choose !== 4'd9)
            $display("FAIL basic_sticky: got st%0d done%b win%b choose%0d want st0 done1 win1 choose9",
                     state, done, win, choose);
        else pass_cnt++;
        check_cnt++;
        if (enter_cnt - base !== 3) $display("FAIL basic_enters: got %0d want 3", enter_cnt - base);
        else pass_cnt++;
    endtask

    task automatic test_retry_skip;
        load_move(4'd0, 4'd3, 2'd1);
        load_move(4'd1, 4'd4, 2'd2);
        exp_q.push_back({4'd3, 2'd1});
        exp_q.push_back({4'd3, 2'd1});
        exp_q.push_back({4'd4, 2'd2});
        start_replay(5'd2);
        wait_enter("retry1");
        reply(1'b0, 1'b1);
        check_cnt++;
        if (state !== S_WRDY || move_idx !== 5'd0 || reject_cnt !== 5'd0)
            $display("FAIL retry_first: got st%0d idx%0d rej%0d want st1 idx0 rej0", state, move_idx, reject_cnt);
        else pass_cnt++;
        wait_enter("retry2");
        reply(1'b0, 1'b1);
        check_cnt++;
        if (state !== S_WRDY || move_idx !== 5'd1 || reject_cnt !== 5'd1)
            $display("FAIL retry_skip: got st%0d idx%0d rej%0d want st1 idx1 rej1", state, move_idx, reject_cnt);
        else pass_cnt++;
        wait_enter("retry3");
        reply(1'b1, 1'b0);
        won = 1'b1;
        @(negedge clk);
        won = 1'b0;
        check_cnt++;
        if (done !== 1'b1 || win !== 1'b1 || reject_cnt !== 5'd1 || move_idx !== 5'd2)
            $display("FAIL retry_done: got done%b win%b rej%0d idx%0d want done1 win1 rej1 idx2",
                     done, win, reject_cnt, move_idx);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_timeout;
        load_move(4'd0, 4'd5, 2'd3);
        exp_q.push_back({4'd5, 2'd3});
        start_replay(5'd1);
        wait_enter("timeout");
        repeat (15) @(negedge clk);
        check_cnt++;
        if (tmo !== 1'b0 || state !== S_WRESP || busy !== 1'b1)
            $display("FAIL timeout_early: got tmo%b st%0d busy%b want tmo0 st4 busy1", tmo, state, busy);
        else pass_cnt++;
        @(negedge clk);
        check_cnt++;
        if (tmo !== 1'b1 || done !== 1'b1 || busy !== 1'b0 || win !== 1'b0 || state !== S_DONE)
            $display("FAIL timeout_fire: got tmo%b done%b busy%b win%b st%0d want tmo1 done1 busy0 win0 st6",
                     tmo, done, busy, win, state);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_both_and_won;
        load_move(4'd0, 4'd7, 2'd2);
        load_move(4'd1, 4'd8, 2'd1);
        exp_q.push_back({4'd7, 2'd2});
        exp_q.push_back({4'd7, 2'd2});
        base = enter_cnt;
        start_replay(5'd2);
        wait_enter("both1");
        reply(1'b1, 1'b1);
        check_cnt++;
        if (state !== S_WRDY || move_idx !== 5'd0 || reject_cnt !== 5'd0)
            $display("FAIL both_is_reject: got st%0d idx%0d rej%0d want st1 idx0 rej0", state, move_idx, reject_cnt);
        else pass_cnt++;
        wait_enter("both2");
        @(negedge clk);
        won = 1'b1;
        @(negedge clk);
        won = 1'b0;
        check_cnt++;
        if (state !== S_DONE || done !== 1'b1 || win !== 1'b1 || move_idx !== 5'd0 || busy !== 1'b0)
            $display("FAIL won_midway: got st%0d done%b win%b idx%0d busy%b want st6 done1 win1 idx0 busy0",
                     state, done, win, move_idx, busy);
        else pass_cnt++;
        repeat (5) @(negedge clk);
        check_cnt++;
        if (state !== S_IDLE || enter_cnt - base !== 2)
            $display("FAIL won_no_more: got st%0d enters%0d want st0 enters2", state, enter_cnt - base);
        else pass_cnt++;
    endtask

    task automatic test_zero_and_busy;
        @(negedge clk);
        start = 1'b1; num = 5'd0;
        @(negedge clk);
        check_cnt++;
        if (state !== S_WWIN || busy !== 1'b1)
            $display("FAIL zero_wait_win: got st%0d busy%b want st5 busy1", state, busy);
        else pass_cnt++;
        num = 5'd1; wr_en = 1'b1; wr_addr = 4'd0; wr_cell = 4'd15; wr_value = 2'd3;
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0;
        repeat (13) @(negedge clk);
        check_cnt++;
        if (done !== 1'b0 || busy !== 1'b1)
            $display("FAIL zero_early: got done%b busy%b want done0 busy1", done, busy);
        else pass_cnt++;
        @(negedge clk);
        check_cnt++;
        if (done !== 1'b1 || win !== 1'b0 || tmo !== 1'b0 || state !== S_DONE)
            $display("FAIL zero_done: got done%b win%b tmo%b st%0d want done1 win0 tmo0 st6", done, win, tmo, state);
        else pass_cnt++;
        repeat (3) @(negedge clk);
        check_cnt++;
        if (state !== S_IDLE || busy !== 1'b0)
            $display("FAIL busy_start_ignored: got st%0d busy%b want st0 busy0", state, busy);
        else pass_cnt++;
        // Slot 0 must still hold the earlier move, not the write issued while busy.
        exp_q.push_back({4'd7, 2'd2});
        start_replay(5'd1);
        wait_enter("busy_wr");
        reply(1'b1, 1'b0);
        won = 1'b1;
        @(negedge clk);
        won = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        load_move(4'd0, 4'd2, 2'd1);
        exp_q.push_back({4'd2, 2'd1});
        start_replay(5'd1);
        wait_enter("rst");
        check_cnt++;
        if (state !== S_ENTER) $display("FAIL rst_pre: got st%0d want st3", state);
        else pass_cnt++;
        restart_n = 1'b0;
        #1;
        check_cnt++;
        if ({enter, busy, done, win, tmo, reject_cnt, move_idx, state, choose, value} !== '0)
            $display("FAIL rst_mid: got enter%b busy%b done%b st%0d choose%0d want all 0",
                     enter, busy, done, state, choose);
        else pass_cnt++;
        @(negedge clk);
        restart_n = 1'b1;
        exp_q.push_back({4'd2, 2'd1});
        start_replay(5'd1);
        wait_enter("rst_replay");
        reply(1'b1, 1'b0);
        won = 1'b1;
        @(negedge clk);
        won = 1'b0;
        check_cnt++;
        if (done !== 1'b1 || win !== 1'b1 || move_idx !== 5'd1)
            $display("FAIL rst_replay: got done%b win%b idx%0d want done1 win1 idx1", done, win, move_idx);
        else pass_cnt++;
        @(negedge clk);
    endtask

    initial begin
        restart_n = 1'b0; start = 1'b0; wr_en = 1'b0; ready = 1'b0;
        dp = 1'b0; ta = 1'b0; won = 1'b0;
        wr_addr = '0; wr_cell = '0; wr_value = '0; num = '0;
        test_reset();
        test_basic();
        test_retry_skip();
        test_timeout();
        test_both_and_won();
        test_zero_and_busy();
        test_reset_mid();
        check_cnt++;
        if (exp_q.size() != 0) $display("FAIL queue_drained: got %0d left want 0", exp_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
